// File: rtl/pc_sequencer.sv
// Registered next-PC unit for the fetch front end.
// Sequential, region jump, branch, register jump, call/return with a circular RAS.
module pc_sequencer #(
    parameter int ADDR_W    = 32,
    parameter int REGION_W  = 4,
    parameter int TGT_W     = 26,
    parameter int OFF_W     = 16,
    parameter int PC_INC    = 1,
    parameter int RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int CNT_W    = $clog2(RAS_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic [2:0]        mode,
    input  logic [TGT_W-1:0]  jtarget,
    input  logic [OFF_W-1:0]  boffset,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus,
    output logic [CNT_W-1:0]  ras_count,
    output logic              ras_ovf,
    output logic              ras_unf
);

    localparam int PAD_W = ADDR_W - REGION_W - TGT_W;
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    localparam logic [2:0] MODE_SEQ  = 3'd0;
    localparam logic [2:0] MODE_JUMP = 3'd1;
    localparam logic [2:0] MODE_BR   = 3'd2;
    localparam logic [2:0] MODE_JR   = 3'd3;
    localparam logic [2:0] MODE_CALL = 3'd4;
    localparam logic [2:0] MODE_RET  = 3'd5;

    // Upper REGION_W bits of pc survive a region jump; the rest come from jtarget.
    localparam logic [ADDR_W-1:0] REGION_MASK =
        ~({ADDR_W{1'b1}} >> REGION_W);

    generate
        if (PAD_W < 0) begin : g_bad_width
            $error("pc_sequencer: REGION_W + TGT_W exceeds ADDR_W");
        end
        if (RAS_DEPTH < 2) begin : g_bad_depth
            $error("pc_sequencer: RAS_DEPTH must be at least 2");
        end
    endgenerate

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_top;
    logic [PTR_W-1:0]  top_inc;
    logic [PTR_W-1:0]  top_dec;
    logic              ras_full;
    logic              ras_empty;

    logic [ADDR_W-1:0] jaddr;
    logic [ADDR_W-1:0] baddr;
    logic [ADDR_W-1:0] boff_ext;
    logic [ADDR_W-1:0] pc_nxt;
    logic              push;
    logic              pop;
    logic              ovf_nxt;
    logic              unf_nxt;

    assign pc_plus  = pc + ADDR_W'(PC_INC);
    assign boff_ext = ADDR_W'($signed(boffset));
    assign jaddr    = (pc & REGION_MASK) | ADDR_W'(jtarget);
    assign baddr    = pc_plus + boff_ext;

    assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
    assign ras_empty = (ras_count == '0);

    assign top_inc = (ras_top == PTR_W'(RAS_DEPTH - 1))
                   ? '0 : ras_top + PTR_W'(1);
    assign top_dec = (ras_top == '0)
                   ? PTR_W'(RAS_DEPTH - 1) : ras_top - PTR_W'(1);

    always_comb begin
        pc_nxt  = pc_plus;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        if (flush) begin
            pc_nxt = flush_pc;
        end else if (!en) begin
            pc_nxt = pc;
        end else begin
            case (mode)
                MODE_SEQ:  pc_nxt = pc_plus;
                MODE_JUMP: pc_nxt = jaddr;
                MODE_BR:   pc_nxt = baddr;
                MODE_JR:   pc_nxt = reg_target;
                MODE_CALL: begin
                    pc_nxt  = jaddr;
                    push    = 1'b1;
                    ovf_nxt = ras_full;
                end
                MODE_RET: begin
                    if (!ras_empty) begin
                        pc_nxt = ras_mem[ras_top];
                        pop    = 1'b1;
                    end else begin
                        unf_nxt = 1'b1;
                    end
                end
                default:   pc_nxt = pc_plus;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            ras_top   <= '0;
            ras_count <= '0;
            ras_ovf   <= 1'b0;
            ras_unf   <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            pc      <= pc_nxt;
            ras_ovf <= ovf_nxt;
            ras_unf <= unf_nxt;
            // A full stack wraps onto its oldest slot, so count saturates.
            if (push) begin
                ras_mem[top_inc] <= pc_plus;
                ras_top          <= top_inc;
                if (!ras_full) begin
                    ras_count <= ras_count + CNT_W'(1);
                end
            end else if (pop) begin
                ras_top   <= top_dec;
                ras_count <= ras_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed table, RAS corner sequences,
// then random traffic against a queue-based reference model.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic [31:0] flush_pc;
    logic [2:0]  mode;
    logic [25:0] jtarget;
    logic [15:0] boffset;
    logic [31:0] reg_target;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic [2:0]  ras_count;
    logic        ras_ovf;
    logic        ras_unf;

    int checks;
    int errors;

    pc_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .mode       (mode),
        .jtarget    (jtarget),
        .boffset    (boffset),
        .reg_target (reg_target),
        .pc         (pc),
        .pc_plus    (pc_plus),
        .ras_count  (ras_count),
        .ras_ovf    (ras_ovf),
        .ras_unf    (ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        fl;
        logic [31:0] fpc;
        logic        en;
        logic [2:0]  md;
        logic [25:0] jt;
        logic [15:0] bo;
        logic [31:0] rt;
        logic [31:0] epc;
        logic [2:0]  ecnt;
        logic        eovf;
        logic        eunf;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(string n, logic fl, logic [31:0] fpc,
                                logic e, logic [2:0] md, logic [25:0] jt,
                                logic [15:0] bo, logic [31:0] rt,
                                logic [31:0] epc, logic [2:0] ecnt,
                                logic eovf, logic eunf);
        vec_t v;
        v.name = n; v.fl = fl; v.fpc = fpc; v.en = e; v.md = md;
        v.jt = jt; v.bo = bo; v.rt = rt; v.epc = epc; v.ecnt = ecnt;
        v.eovf = eovf; v.eunf = eunf;
        tbl.push_back(v);
    endfunction

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic fl, logic [31:0] fpc, logic e, logic [2:0] md,
                         logic [25:0] jt, logic [15:0] bo, logic [31:0] rt);
        flush = fl; flush_pc = fpc; en = e; mode = md;
        jtarget = jt; boffset = bo; reg_target = rt;
    endtask

    task automatic go_to(logic [31:0] a);
        drive(1'b1, a, 1'b1, 3'd0, '0, '0, '0);
        step();
    endtask

    task automatic call_ret(logic [2:0] md, logic [25:0] jt);
        drive(1'b0, '0, 1'b1, md, jt, '0, '0);
        step();
    endtask

    // Reference model: abstract stack of return addresses, oldest at front.
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_ovf;
    logic        m_unf;

    task automatic model_edge();
        logic [31:0] nxt;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        nxt = m_pc;
        if (flush) begin
            nxt = flush_pc;
        end else if (en) begin
            case (mode)
                3'd1: nxt = {m_pc[31:28], 2'b00, jtarget};
                3'd2: nxt = m_pc + 32'd1 + {{16{boffset[15]}}, boffset};
                3'd3: nxt = reg_target;
                3'd4: begin
                    nxt = {m_pc[31:28], 2'b00, jtarget};
                    if (m_ras.size() == 4) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_ras.push_back(m_pc + 32'd1);
                end
                3'd5: begin
                    if (m_ras.size() > 0) nxt = m_ras.pop_back();
                    else begin
                        nxt = m_pc + 32'd1;
                        m_unf = 1'b1;
                    end
                end
                default: nxt = m_pc + 32'd1;
            endcase
        end
        m_pc = nxt;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 3'd0, '0, '0, '0);
        #2;
        chk("reset_pc", pc, 32'h0);
        chk("reset_cnt", 32'(ras_count), 32'd0);
        chk("reset_pulses", {30'd0, ras_ovf, ras_unf}, 32'd0);
        #10;
        rst_n = 1'b1;

        // Async reset mid-cycle
        go_to(32'h40);
        chk("pre_async_pc", pc, 32'h40);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pc", pc, 32'h0);
        chk("async_cnt", 32'(ras_count), 32'd0);
        #2;
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b1, 3'd0, '0, '0, '0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("post_rst_seq%0d", i), pc, 32'(i));
        end

        add("flush_a",   1, 32'h30000010, 1, 0, '0, '0, '0, 32'h30000010, 0, 0, 0);
        add("jump_stall",0, '0, 0, 1, 26'h0123456, '0, '0, 32'h30000010, 0, 0, 0);
        add("jump",      0, '0, 1, 1, 26'h0123456, '0, '0, 32'h30123456, 0, 0, 0);
        add("flush_b",   1, 32'h100, 0, 0, '0, '0, '0, 32'h100, 0, 0, 0);
        add("br_neg",    0, '0, 1, 2, '0, 16'hFFFE, '0, 32'hFF, 0, 0, 0);
        add("flush_c",   1, 32'h100, 1, 0, '0, '0, '0, 32'h100, 0, 0, 0);
        add("br_pos",    0, '0, 1, 2, '0, 16'h0010, '0, 32'h111, 0, 0, 0);
        add("flush_d",   1, 32'hFFFFFFFF, 1, 0, '0, '0, '0, 32'hFFFFFFFF, 0, 0, 0);
        add("seq_wrap",  0, '0, 1, 0, '0, '0, '0, 32'h0, 0, 0, 0);
        add("jreg",      0, '0, 1, 3, '0, '0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
        add("mode6",     0, '0, 1, 6, '0, '0, '0, 32'hDEADBEF0, 0, 0, 0);
        add("mode7",     0, '0, 1, 7, '0, '0, '0, 32'hDEADBEF1, 0, 0, 0);
        add("flush_e",   1, 32'h200, 1, 0, '0, '0, '0, 32'h200, 0, 0, 0);
        add("call",      0, '0, 1, 4, 26'h40, '0, '0, 32'h40, 1, 0, 0);
        add("ret_b2b",   0, '0, 1, 5, '0, '0, '0, 32'h201, 0, 0, 0);
        add("flush_f",   1, 32'h200, 1, 0, '0, '0, '0, 32'h200, 0, 0, 0);
        add("call2",     0, '0, 1, 4, 26'h40, '0, '0, 32'h40, 1, 0, 0);
        add("flush_pri", 1, 32'h8000, 0, 4, 26'h77, '0, '0, 32'h8000, 1, 0, 0);
        add("ret_after", 0, '0, 1, 5, '0, '0, '0, 32'h201, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].fl, tbl[i].fpc, tbl[i].en, tbl[i].md,
                  tbl[i].jt, tbl[i].bo, tbl[i].rt);
            step();
            chk({tbl[i].name, "_pc"}, pc, tbl[i].epc);
            chk({tbl[i].name, "_cnt"}, 32'(ras_count), 32'(tbl[i].ecnt));
            chk({tbl[i].name, "_ovf"}, 32'(ras_ovf), 32'(tbl[i].eovf));
            chk({tbl[i].name, "_unf"}, 32'(ras_unf), 32'(tbl[i].eunf));
        end

        // Call, stall, return
        go_to(32'h200);
        call_ret(3'd4, 26'h40);
        drive(1'b0, '0, 1'b0, 3'd5, '0, '0, '0);
        step();
        chk("stall_hold_pc", pc, 32'h40);
        chk("stall_hold_cnt", 32'(ras_count), 32'd1);
        call_ret(3'd5, '0);
        chk("stall_ret_pc", pc, 32'h201);

        // Overflow then underflow
        for (int i = 1; i <= 5; i++) begin
            go_to(32'(i * 16));
            call_ret(3'd4, 26'h99);
            chk($sformatf("ovf_call%0d", i), 32'(ras_ovf), (i == 5) ? 32'd1 : 32'd0);
            chk($sformatf("ovf_cnt%0d", i), 32'(ras_count), (i > 4) ? 32'd4 : 32'(i));
        end
        for (int k = 1; k <= 4; k++) begin
            call_ret(3'd5, '0);
            chk($sformatf("ret%0d_pc", k), pc, 32'(16 * (6 - k) + 1));
            chk($sformatf("ret%0d_cnt", k), 32'(ras_count), 32'(4 - k));
            chk($sformatf("ret%0d_ovf", k), 32'(ras_ovf), 32'd0);
        end
        call_ret(3'd5, '0);
        chk("unf_pc", pc, 32'h22);
        chk("unf_pulse", 32'(ras_unf), 32'd1);
        chk("unf_cnt", 32'(ras_count), 32'd0);
        call_ret(3'd0, '0);
        chk("unf_clear", 32'(ras_unf), 32'd0);
        chk("unf_seq_pc", pc, 32'h23);

        // Random traffic against the model
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        m_pc = 32'h0;
        m_ras.delete();
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 15) == 0), $urandom,
                  ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  26'($urandom), 16'($urandom), $urandom);
            model_edge();
            step();
            chk("rnd_pc", pc, m_pc);
            chk("rnd_plus", pc_plus, m_pc + 32'd1);
            chk("rnd_cnt", 32'(ras_count), 32'(m_ras.size()));
            chk("rnd_ovf", 32'(ras_ovf), 32'(m_ovf));
            chk("rnd_unf", 32'(ras_unf), 32'(m_unf));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Registered program-counter sequencer for the CPU front end.
- Generalises the fixed 32-bit region/jump-target concatenation into a parametrised next-PC unit.
- Modes: sequential, region jump, PC-relative branch, register jump, call and return.
- Includes a circular return-address stack (RAS).
- Feeds instruction fetch. The decode/control stage drives mode, target fields, stall and flush.

Parameters:
ADDR_W, 32, PC/address width.
REGION_W, 4, number of upper PC bits kept on a region jump.
TGT_W, 26, width of the jump target field (R1,R2,Immediate = 5+5+16).
OFF_W, 16, branch offset width (two's complement).
PC_INC, 1, sequential increment.
RAS_DEPTH, 4, return stack entries (>=2).
RESET_PC, 0, PC value after reset.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  advance enable; 0 = stall.
flush  in  1  redirect request; highest priority.
flush_pc  in  ADDR_W  redirect address.
mode  in  3  0 seq, 1 jump, 2 branch, 3 jump-reg, 4 call, 5 return, 6/7 = seq.
jtarget  in  TGT_W  region jump target field.
boffset  in  OFF_W  signed branch offset.
reg_target  in  ADDR_W  register jump address.
pc  out  ADDR_W  current PC (registered).
pc_plus  out  ADDR_W  pc + PC_INC (combinational).
ras_count  out  clog2(RAS_DEPTH+1)  valid RAS entries.
ras_ovf  out  1  one-cycle pulse: call pushed while full.
ras_unf  out  1  one-cycle pulse: return popped while empty.

Behaviour:
- Elaboration: ADDR_W - REGION_W - TGT_W must be >= 0; the gap is PAD_W.
- Region jump address = {pc[ADDR_W-1 -: REGION_W], PAD_W zeros, jtarget}. No word shift.
- Branch address = pc + PC_INC + sign_extend(boffset). Arithmetic is modulo 2^ADDR_W and wraps silently.
- Reset (rst_n low, async, any time):
  - pc = RESET_PC.
  - ras_count = 0, top pointer = 0, all entries = 0.
  - ras_ovf = ras_unf = 0.
  - Takes effect immediately, without waiting for a clock edge. Normal operation resumes on the first rising edge after rst_n rises.
- Each rising edge, priority order:
  - 1. flush=1: pc <= flush_pc regardless of en. RAS unchanged. Pulses 0.
  - 2. en=0: all state held. Pulses 0.
  - 3. en=1, by mode:
    - seq: pc <= pc + PC_INC.
    - jump: pc <= region jump address.
    - branch: pc <= branch address.
    - jump-reg: pc <= reg_target.
    - call: pc <= region jump address. Push pc + PC_INC.
    - return: if ras_count > 0, pc <= top entry, pop. Else pc <= pc + PC_INC and ras_unf pulses.
- Push rules:
  - The top pointer advances circularly modulo RAS_DEPTH and the entry is written there.
  - If ras_count < RAS_DEPTH, count increments.
  - If full, the oldest entry is overwritten, count stays at RAS_DEPTH and ras_ovf pulses.
- Pop rules: read the entry at the top pointer, retreat the pointer circularly, decrement count.
- Latency: mode/targets sampled at edge N produce the new pc after edge N. Zero bubbles. A call and an immediately following return in consecutive cycles are legal and must return the correct address.
- Pulses last exactly one cycle and are registered alongside pc.

Test Plan:
- Reset/async: drive rst_n low mid-cycle with pc=0x00000040 -> pc=0x00000000 before the next edge, ras_count=0. Release, 3 seq cycles -> pc=1,2,3.
- Region jump: pc=0x30000010, mode=1, jtarget=26'h0123456 -> pc=0x30123456. With en=0 the same inputs -> pc holds 0x30000010.
- Branch: pc=0x00000100, boffset=16'hFFFE -> pc=0x000000FF. boffset=16'h0010 -> 0x00000111. pc=0xFFFFFFFF, seq -> 0x00000000 (wrap).
- Call/return: pc=0x200, call jtarget=0x40 -> pc=0x40, ras_count=1. Return -> pc=0x201, ras_count=0. Back-to-back call then return gives the same result.
- RAS overflow/underflow (RAS_DEPTH=4): 5 calls from pc=0x10,0x20,0x30,0x40,0x50 -> ras_ovf pulses only on the 5th, count=4. 4 returns -> 0x51,0x41,0x31,0x21. 5th return -> pc+1, ras_unf pulse, count=0.
- Flush priority: flush=1, flush_pc=0x8000, en=0, mode=call -> pc=0x8000, ras_count unchanged, no pulses.
